mag_compare_seq: RTL and testbench
==================================

Name: mag_compare_seq

Overview:
- Parametrised, digit-serial magnitude comparator; successor to the 4-bit combinational subtract-and-flag comparator.
- Accepts an operand pair via valid/ready and computes A−B over WIDTH/DIGIT cycles with a registered carry chain.
- Reports lt/eq/gt plus the difference, in unsigned or two's-complement mode, then holds the result until the consumer accepts it.
- Drives the board's single-digit seven-segment display with the low nibble of the difference.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT and ≥ 4.
- DIGIT, 2, bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.
- diff  out  WIDTH  (A − B) mod 2^WIDTH.
- seg  out  7  active-low segments a..g, seg[6]=a, seg[0]=g.
- an  out  4  digit enables, constant 4'b1110.
- dp  out  1  decimal point, constant 1 (off).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - in_ready=1, out_valid=0, lt=eq=gt=0, diff=0.
  - Internal operands, carry and zero flag cleared.
  - seg shows "0" (7'b0000001).
- States: IDLE, RUN, DONE. NDIG = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge k: latch a and ~b, carry=1, zero=1, digit index=0, go to RUN.
  - in_ready deasserts after that edge.
- RUN:
  - Each cycle adds the current DIGIT-bit slice (LSB first): a_slice + ~b_slice + carry.
  - The sum is written into the diff shift register, carry is updated, and zero &= (slice sum == 0).
  - In the final digit, record carry-into-MSB and carry-out.
  - After NDIG cycles go to DONE: out_valid rises after edge k+NDIG (latency NDIG cycles from acceptance).
- Result flags (registered on entry to DONE; exactly one of lt/eq/gt is 1):
  - eq = zero.
  - Unsigned: lt = ~carry_out, gt = carry_out & ~zero.
  - Signed: lt = diff[WIDTH-1] XOR (carry_into_msb XOR carry_out), gt = ~lt & ~zero.
- DONE:
  - out_valid=1; lt/eq/gt/diff are held stable while out_ready=0.
  - On out_ready=1, return to IDLE at that edge: out_valid=0, in_ready=1 the next cycle.
  - lt/eq/gt/diff keep their last values until the next DONE entry.
  - No overlap: a new operand is never accepted in the same cycle a result is consumed.
- in_valid while not IDLE: ignored; the bench must hold it.
- a/b changes during RUN have no effect (latched copies are used).
- rst_n low mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.
- seg: combinational from the diff register bits [3:0], hex glyphs:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - seg may show intermediate values during RUN; it is defined only while out_valid=1 or after reset.
- DIGIT == WIDTH: NDIG=1, result valid one cycle after acceptance.

Test Plan:
- WIDTH=8, DIGIT=2, SIGNED=0: a=0x5A, b=0x3C → out_valid 4 cycles after accept; gt=1, diff=0x1E, seg=0110000.
- Same configuration: a=b=0x77 → eq=1, lt=gt=0, diff=0x00, seg=0000001; then a=0x80, b=0x01 → gt=1, diff=0x7F.
- SIGNED=1, WIDTH=8, DIGIT=2: a=0x80 (−128), b=0x01 → lt=1, diff=0x7F (overflow case); a=0x05, b=0xFB (−5) → gt=1, diff=0x0A, seg=0001000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → lt/eq/gt/diff/out_valid stable, in_ready=0; in_valid pulses ignored; out_ready=1 → in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 two cycles after accept → outputs return to reset values immediately with no out_valid; a new a=0x10, b=0x20 accepted after release gives lt=1, diff=0xF0.
- DIGIT=WIDTH=8: a=0xFF, b=0x00 → out_valid 1 cycle after accept, gt=1, diff=0xFF, seg=0111000; back-to-back transactions with out_ready tied high each take NDIG+2 cycles.

Source files
------------

// File: rtl/mag_compare_seq.sv
// Digit-serial magnitude comparator: computes A-B one DIGIT-bit slice per cycle,
// reports lt/eq/gt and the difference, and shows the low nibble on a 7-seg digit.
module mag_compare_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] diff,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, nb_q, acc_q, diff_q;
  logic             carry_q, zero_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q, out_valid_q, lt_q, eq_q, gt_q;

  logic [DIGIT:0]   sum_d;
  logic [WIDTH-1:0] acc_d;
  logic             zero_d, cmsb_d, lt_d, eq_d, gt_d, last_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b0000001;
      4'h1: hex_glyph = 7'b1001111;
      4'h2: hex_glyph = 7'b0010010;
      4'h3: hex_glyph = 7'b0000110;
      4'h4: hex_glyph = 7'b1001100;
      4'h5: hex_glyph = 7'b0100100;
      4'h6: hex_glyph = 7'b0100000;
      4'h7: hex_glyph = 7'b0001111;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0000100;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b1100000;
      4'hC: hex_glyph = 7'b0110001;
      4'hD: hex_glyph = 7'b1000010;
      4'hE: hex_glyph = 7'b0110000;
      default: hex_glyph = 7'b0111000;
    endcase
  endfunction

  // One slice of A + ~B + carry; the new slice enters the accumulator at the top.
  always_comb begin
    sum_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, nb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    acc_d  = (acc_q >> DIGIT) | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    zero_d = zero_q & (sum_d[DIGIT-1:0] == '0);
    cmsb_d = a_q[DIGIT-1] ^ nb_q[DIGIT-1] ^ sum_d[DIGIT-1];
    last_d = (idx_q == IW'(NDIG - 1));
    eq_d   = zero_d;
    if (SIGNED) begin
      lt_d = sum_d[DIGIT-1] ^ (cmsb_d ^ sum_d[DIGIT]);
      gt_d = ~lt_d & ~zero_d;
    end else begin
      lt_d = ~sum_d[DIGIT];
      gt_d = sum_d[DIGIT] & ~zero_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      acc_q       <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            nb_q       <= ~b;
            carry_q    <= 1'b1;
            zero_q     <= 1'b1;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          nb_q    <= nb_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= sum_d[DIGIT];
          zero_q  <= zero_d;
          idx_q   <= idx_q + 1'b1;
          if (last_d) begin
            diff_q      <= acc_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign diff      = diff_q;
  assign seg       = hex_glyph(diff_q[3:0]);
  assign an        = 4'b1110;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Bench for mag_compare_seq: three configurations (unsigned 8/2, signed 8/2,
// unsigned 8/8) driven with directed and random operand pairs.
module tb_mag_compare_seq;

  localparam int NDG [3] = '{4, 4, 1};
  localparam int SGN [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv [3];
  logic       ordy [3];
  logic       ir [3];
  logic       ov [3];
  logic       lt_w [3];
  logic       eq_w [3];
  logic       gt_w [3];
  logic       dp_w [3];
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];
  logic [7:0] df [3];
  logic [6:0] sg [3];
  logic [3:0] an_w [3];
  logic [6:0] glyph [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mag_compare_seq #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_v[0]), .b(b_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .lt(lt_w[0]), .eq(eq_w[0]), .gt(gt_w[0]),
    .diff(df[0]), .seg(sg[0]), .an(an_w[0]), .dp(dp_w[0]));

  mag_compare_seq #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_v[1]), .b(b_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .lt(lt_w[1]), .eq(eq_w[1]), .gt(gt_w[1]),
    .diff(df[1]), .seg(sg[1]), .an(an_w[1]), .dp(dp_w[1]));

  mag_compare_seq #(.WIDTH(8), .DIGIT(8), .SIGNED(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_v[2]), .b(b_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .lt(lt_w[2]), .eq(eq_w[2]), .gt(gt_w[2]),
    .diff(df[2]), .seg(sg[2]), .an(an_w[2]), .dp(dp_w[2]));

  // Reference: integer comparison of the operands as the mode interprets them.
  task automatic model(input int d, input logic [7:0] av, input logic [7:0] bv,
                       output logic [2:0] flags, output logic [7:0] ed);
    int ia, ib;
    ia = (SGN[d] != 0) ? int'($signed(av)) : int'(av);
    ib = (SGN[d] != 0) ? int'($signed(bv)) : int'(bv);
    flags = {ia < ib, ia == ib, ia > ib};
    ed = av - bv;
  endtask

  task automatic run_txn(input int d, input logic [7:0] av, input logic [7:0] bv, input int hold);
    logic [2:0] ef;
    logic [7:0] ed;
    int lat;
    model(d, av, bv, ef, ed);
    checks++;
    if (ir[d] !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready dut%0d: got %b want 1", d, ir[d]);
    end
    a_v[d] = av; b_v[d] = bv; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0; a_v[d] = 8'($urandom); b_v[d] = 8'($urandom);
    checks++;
    if (ir[d] !== 1'b0 || ov[d] !== 1'b0) begin
      errors++; $display("FAIL accept_state dut%0d: in_ready=%b out_valid=%b want 0/0", d, ir[d], ov[d]);
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ov[d] !== 1'b1 && lat < 40);
    checks++;
    if (lat != NDG[d]) begin
      errors++; $display("FAIL latency dut%0d a=%h b=%h: got %0d want %0d", d, av, bv, lat, NDG[d]);
    end
    checks++;
    if ({lt_w[d], eq_w[d], gt_w[d]} !== ef || df[d] !== ed || sg[d] !== glyph[ed[3:0]]) begin
      errors++;
      $display("FAIL result dut%0d a=%h b=%h: got ltegt=%b diff=%h seg=%b want %b %h %b",
               d, av, bv, {lt_w[d], eq_w[d], gt_w[d]}, df[d], sg[d], ef, ed, glyph[ed[3:0]]);
    end
    for (int i = 0; i < hold; i++) begin
      iv[d] = 1'($urandom); a_v[d] = 8'($urandom); b_v[d] = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || {lt_w[d], eq_w[d], gt_w[d]} !== ef || df[d] !== ed) begin
        errors++;
        $display("FAIL hold dut%0d cyc%0d: ov=%b ir=%b ltegt=%b diff=%h want 1 0 %b %h",
                 d, i, ov[d], ir[d], {lt_w[d], eq_w[d], gt_w[d]}, df[d], ef, ed);
      end
    end
    iv[d] = 1'b0; ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    checks++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || df[d] !== ed || {lt_w[d], eq_w[d], gt_w[d]} !== ef) begin
      errors++;
      $display("FAIL release dut%0d: ov=%b ir=%b diff=%h ltegt=%b want 0 1 %h %b",
               d, ov[d], ir[d], df[d], {lt_w[d], eq_w[d], gt_w[d]}, ed, ef);
    end
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    checks++;
    if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || {lt_w[d], eq_w[d], gt_w[d]} !== 3'b000 ||
        df[d] !== 8'h00 || sg[d] !== 7'b0000001 || an_w[d] !== 4'b1110 || dp_w[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s dut%0d: ir=%b ov=%b ltegt=%b diff=%h seg=%b an=%b dp=%b want 1 0 000 00 0000001 1110 1",
               tag, d, ir[d], ov[d], {lt_w[d], eq_w[d], gt_w[d]}, df[d], sg[d], an_w[d], dp_w[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(0, 8'h5A, 8'h3C, 0);
    run_txn(0, 8'h77, 8'h77, 1);
    run_txn(0, 8'h80, 8'h01, 0);
    run_txn(0, 8'h00, 8'hFF, 0);
    run_txn(1, 8'h80, 8'h01, 0);
    run_txn(1, 8'h05, 8'hFB, 0);
    run_txn(1, 8'h7F, 8'h80, 0);
    run_txn(1, 8'hC0, 8'hC0, 0);
    run_txn(2, 8'hFF, 8'h00, 0);
    run_txn(2, 8'h00, 8'h01, 0);
  endtask

  task automatic test_backpressure();
    run_txn(0, 8'h12, 8'h34, 5);
    run_txn(1, 8'hF0, 8'h0F, 5);
    run_txn(2, 8'hAB, 8'hAB, 5);
  endtask

  task automatic test_reset_mid_run();
    a_v[0] = 8'h33; b_v[0] = 8'h11; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_reset_vals(0, "reset_mid_run");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++; $display("FAIL discarded_result: out_valid got %b want 0", ov[0]);
    end
    run_txn(0, 8'h10, 8'h20, 0);
  endtask

  task automatic test_back_to_back(input int d, input int n);
    logic [7:0] ca, cb, ed;
    logic [2:0] ef;
    int cyc, prev, got;
    ca = 8'($urandom); cb = 8'($urandom);
    a_v[d] = ca; b_v[d] = cb; ordy[d] = 1'b1; iv[d] = 1'b1;
    cyc = 0; prev = -1; got = 0;
    while (got < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ov[d] === 1'b1) begin
        model(d, ca, cb, ef, ed);
        checks++;
        if ({lt_w[d], eq_w[d], gt_w[d]} !== ef || df[d] !== ed) begin
          errors++;
          $display("FAIL b2b_result dut%0d a=%h b=%h: got %b %h want %b %h",
                   d, ca, cb, {lt_w[d], eq_w[d], gt_w[d]}, df[d], ef, ed);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != NDG[d] + 2) begin
            errors++; $display("FAIL b2b_period dut%0d: got %0d want %0d", d, cyc - prev, NDG[d] + 2);
          end
        end
        prev = cyc; got++;
        ca = 8'($urandom); cb = 8'($urandom);
        a_v[d] = ca; b_v[d] = cb;
        if (got == n) iv[d] = 1'b0;
      end
    end
    checks++;
    if (got != n) begin
      errors++; $display("FAIL b2b_count dut%0d: got %0d results want %0d", d, got, n);
    end
    iv[d] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ordy[d] = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      for (int d = 0; d < 3; d++) begin
        run_txn(d, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; a_v[d] = 8'h00; b_v[d] = 8'h00;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back(0, 6);
    test_back_to_back(1, 6);
    test_back_to_back(2, 8);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
